mem_req_arbiter: RTL

Memory request arbiter for the tiny-GPU memory path. Accepts load/store requests from NUM_CH core-side channels and grants one at a time, round-robin. It drives the single-port data memory stage (en/wr/addr/wdata in, src_data out) and returns read data or write acknowledgements to the requesting channel over a valid/ready handshake. Sits directly upstream of the memory block and feeds it.

---
 rtl/gpu_mem_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/mem_req_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the tiny-GPU memory path: arbiter state codes and
// the default address/data widths used by the arbiter and the memory stage.
package gpu_mem_pkg;

   localparam int GPU_ADDR_W = 8;
   localparam int GPU_DATA_W = 8;

   // Arbiter FSM state codes.
   typedef logic [1:0] arb_state_t;
   localparam arb_state_t ST_IDLE  = 2'd0;
   localparam arb_state_t ST_ISSUE = 2'd1;
   localparam arb_state_t ST_WAIT  = 2'd2;
   localparam arb_state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the lowest-index requester at or
// after ptr, wrapping modulo N. Returns a one-hot grant and its index.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] idx;
   logic             found;

   // Scan the requesters starting at ptr and stop at the first one set.
   always_comb begin
      // NOTE: every output gets a default before the loop; a path that left one
      // unassigned would make synthesis infer a latch.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         // NOTE: blocking '=' here so later iterations see 'found' immediately;
         // clocked state elsewhere uses non-blocking '<='.
         idx = IDX_W'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Memory request arbiter: grants one core-side channel at a time round-robin,
// drives the single-port memory stage and returns read data or a write ack to
// the granted channel. One transaction outstanding at a time.
module mem_req_arbiter
   import gpu_mem_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = GPU_ADDR_W,
   parameter int DATA_W = GPU_DATA_W,
   parameter int RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        req_valid,
   output logic [NUM_CH-1:0]        req_ready,
   input  logic [NUM_CH-1:0]        req_wr,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_wdata,
   output logic [NUM_CH-1:0]        rsp_valid,
   input  logic [NUM_CH-1:0]        rsp_ready,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     mem_en,
   output logic                     mem_wr,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata
);

   localparam int IDX_W = $clog2(NUM_CH);
   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

   arb_state_t       state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] gnt_q;
   logic [CNT_W-1:0] cnt;
   logic [NUM_CH-1:0] grant;
   logic [IDX_W-1:0] grant_idx;

   rr_arbiter #(
      .N     (NUM_CH),
      .IDX_W (IDX_W)
   ) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Grant is offered only while idle; held low during reset so no channel
   // sees an acceptance the clock cannot act on.
   assign req_ready = (rst_n && state == ST_IDLE) ? grant : '0;

   // Transaction FSM with registered memory-side and response-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         gnt_q     <= '0;
         cnt       <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req_ready) begin
                  gnt_q     <= grant_idx;
                  rr_ptr    <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
                  mem_en    <= 1'b1;
                  mem_wr    <= req_wr[grant_idx];
                  mem_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                  mem_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // The strobe lasts exactly this one cycle; mem_wr still holds
               // the latched direction here.
               mem_en <= 1'b0;
               mem_wr <= 1'b0;
               if (mem_wr) begin
                  rsp_rdata <= '0;
                  rsp_valid <= NUM_CH'(1) << gnt_q;
                  state     <= ST_RESP;
               end else begin
                  cnt   <= CNT_LOAD;
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  rsp_rdata <= mem_rdata;
                  rsp_valid <= NUM_CH'(1) << gnt_q;
                  state     <= ST_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready[gnt_q]) begin
                  rsp_valid <= '0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
